// File: rtl/serdesphy_csr_pkg.sv
// Shared register map, bit positions and reset constants for the PHY CSR bank.
package serdesphy_csr_pkg;

  localparam int unsigned IRQ_W = 3;

  localparam logic [7:0] ADDR_ID       = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h01;
  localparam logic [7:0] ADDR_PLL_CFG  = 8'h02;
  localparam logic [7:0] ADDR_CMD      = 8'h03;
  localparam logic [7:0] ADDR_STATUS   = 8'h04;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h05;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h06;
  localparam logic [7:0] ADDR_SCRATCH  = 8'h07;

  localparam int unsigned CTRL_TX_EN    = 0;
  localparam int unsigned CTRL_RX_EN    = 1;
  localparam int unsigned CTRL_LOOPBACK = 2;

  localparam int unsigned CMD_APPLY      = 0;
  localparam int unsigned CMD_SOFT_RESET = 1;

  localparam int unsigned IRQ_LOCK_LOST = 0;
  localparam int unsigned IRQ_FIFO_OVF  = 1;
  localparam int unsigned IRQ_I2C_ERR   = 2;

  localparam logic [2:0]       CTRL_RST     = '0;
  localparam logic [IRQ_W-1:0] IRQ_STAT_RST = '0;
  localparam logic [IRQ_W-1:0] IRQ_MASK_RST = '0;
  localparam logic [7:0]       SCRATCH_RST  = '0;

endpackage

// File: rtl/serdesphy_sync2.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module serdesphy_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/serdesphy_csr_regfile.sv
// PHY CSR bank behind the I2C slave: control/config registers, sticky W1C
// interrupt status, shadowed PLL config with apply strobe, and registered irq.
module serdesphy_csr_regfile
  import serdesphy_csr_pkg::*;
#(
  parameter logic [7:0] CHIP_ID     = 8'hA5,
  parameter logic [7:0] PLL_CFG_RST = 8'h14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_write_en,
  input  logic       reg_read_en,
  output logic [7:0] reg_rdata,
  input  logic       pll_lock_async,
  input  logic       cdr_lock_async,
  input  logic       fifo_ovf_pulse,
  input  logic       i2c_error,
  output logic       tx_en,
  output logic       rx_en,
  output logic       loopback,
  output logic [7:0] pll_cfg,
  output logic       soft_reset_pulse,
  output logic       irq
);

  logic             pll_sync, cdr_sync;
  logic             we_prev_q, we_prev_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       pll_cfg_q, pll_cfg_d;
  logic [IRQ_W-1:0] stat_q, stat_d;
  logic [IRQ_W-1:0] mask_q, mask_d;
  logic [7:0]       scratch_q, scratch_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             srp_q, srp_d;
  logic             irq_q, irq_d;
  logic             pll_hist_q, pll_hist_d;
  logic             i2c_prev_q, i2c_prev_d;
  logic             commit;
  logic [IRQ_W-1:0] set_ev, clr_mask;
  logic             unused_read_en;

  assign unused_read_en = reg_read_en;

  serdesphy_sync2 u_sync_pll (.clk(clk), .rst(rst), .d(pll_lock_async), .q(pll_sync));
  serdesphy_sync2 u_sync_cdr (.clk(clk), .rst(rst), .d(cdr_lock_async), .q(cdr_sync));

  always_comb begin
    commit     = reg_write_en & ~we_prev_q;
    we_prev_d  = reg_write_en;
    pll_hist_d = pll_sync;
    i2c_prev_d = i2c_error;

    ctrl_d    = ctrl_q;
    shadow_d  = shadow_q;
    pll_cfg_d = pll_cfg_q;
    mask_d    = mask_q;
    scratch_d = scratch_q;
    srp_d     = 1'b0;
    clr_mask  = '0;

    if (commit) begin
      case (reg_addr)
        ADDR_CTRL:     ctrl_d    = reg_wdata[2:0];
        ADDR_PLL_CFG:  shadow_d  = reg_wdata;
        ADDR_CMD: begin
          if (reg_wdata[CMD_APPLY]) pll_cfg_d = shadow_q;
          srp_d = reg_wdata[CMD_SOFT_RESET];
        end
        ADDR_IRQ_STAT: clr_mask  = reg_wdata[IRQ_W-1:0];
        ADDR_IRQ_MASK: mask_d    = reg_wdata[IRQ_W-1:0];
        ADDR_SCRATCH:  scratch_d = reg_wdata;
        default: ;
      endcase
    end

    // Set events are applied after the W1C clear so a coincident event wins.
    set_ev                = '0;
    set_ev[IRQ_LOCK_LOST] = pll_hist_q & ~pll_sync;
    set_ev[IRQ_FIFO_OVF]  = fifo_ovf_pulse;
    set_ev[IRQ_I2C_ERR]   = i2c_error & ~i2c_prev_q;
    stat_d = (stat_q & ~clr_mask) | set_ev;

    irq_d = |(stat_q & mask_q);

    case (reg_addr)
      ADDR_ID:       rdata_d = CHIP_ID;
      ADDR_CTRL:     rdata_d = {5'b0, ctrl_q};
      ADDR_PLL_CFG:  rdata_d = shadow_q;
      ADDR_STATUS:   rdata_d = {6'b0, cdr_sync, pll_sync};
      ADDR_IRQ_STAT: rdata_d = {{(8-IRQ_W){1'b0}}, stat_q};
      ADDR_IRQ_MASK: rdata_d = {{(8-IRQ_W){1'b0}}, mask_q};
      ADDR_SCRATCH:  rdata_d = scratch_q;
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_prev_q  <= 1'b1;
      ctrl_q     <= CTRL_RST;
      shadow_q   <= PLL_CFG_RST;
      pll_cfg_q  <= PLL_CFG_RST;
      stat_q     <= IRQ_STAT_RST;
      mask_q     <= IRQ_MASK_RST;
      scratch_q  <= SCRATCH_RST;
      rdata_q    <= '0;
      srp_q      <= 1'b0;
      irq_q      <= 1'b0;
      pll_hist_q <= 1'b0;
      i2c_prev_q <= 1'b0;
    end else begin
      we_prev_q  <= we_prev_d;
      ctrl_q     <= ctrl_d;
      shadow_q   <= shadow_d;
      pll_cfg_q  <= pll_cfg_d;
      stat_q     <= stat_d;
      mask_q     <= mask_d;
      scratch_q  <= scratch_d;
      rdata_q    <= rdata_d;
      srp_q      <= srp_d;
      irq_q      <= irq_d;
      pll_hist_q <= pll_hist_d;
      i2c_prev_q <= i2c_prev_d;
    end
  end

  assign reg_rdata        = rdata_q;
  assign tx_en            = ctrl_q[CTRL_TX_EN];
  assign rx_en            = ctrl_q[CTRL_RX_EN];
  assign loopback         = ctrl_q[CTRL_LOOPBACK];
  assign pll_cfg          = pll_cfg_q;
  assign soft_reset_pulse = srp_q;
  assign irq              = irq_q;

endmodule

// File: tb/tb_serdesphy_csr_regfile.sv
// Directed self-checking bench for the PHY CSR bank.
module tb_serdesphy_csr_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg_addr, reg_wdata, reg_rdata, pll_cfg;
  logic       reg_write_en, reg_read_en;
  logic       pll_lock_async, cdr_lock_async, fifo_ovf_pulse, i2c_error;
  logic       tx_en, rx_en, loopback, soft_reset_pulse, irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  serdesphy_csr_regfile #(.CHIP_ID(8'hA5), .PLL_CFG_RST(8'h14)) dut (
    .clk(clk), .rst(rst),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
    .reg_rdata(reg_rdata),
    .pll_lock_async(pll_lock_async), .cdr_lock_async(cdr_lock_async),
    .fifo_ovf_pulse(fifo_ovf_pulse), .i2c_error(i2c_error),
    .tx_en(tx_en), .rx_en(rx_en), .loopback(loopback),
    .pll_cfg(pll_cfg), .soft_reset_pulse(soft_reset_pulse), .irq(irq)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_write_en = 1'b1;
    tick();
    reg_write_en = 1'b0;
    tick();
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    reg_addr = a;
    tick();
    check(tag, reg_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; reg_addr = '0; reg_wdata = '0; reg_write_en = 1'b0; reg_read_en = 1'b0;
    pll_lock_async = 1'b0; cdr_lock_async = 1'b0; fifo_ovf_pulse = 1'b0; i2c_error = 1'b0;
    tick(2);
    check("rst_rdata", reg_rdata, 8'h00);
    check("rst_ctrl", {5'b0, loopback, rx_en, tx_en}, 8'h00);
    check("rst_pll_cfg", pll_cfg, 8'h14);
    check("rst_srp_irq", {6'b0, soft_reset_pulse, irq}, 8'h00);
    rst = 1'b0;
    reg_read_en = 1'b1;
    rd("id", 8'h00, 8'hA5);

    // Held write_en: data changes mid-hold must not re-commit
    reg_addr = 8'h07; reg_wdata = 8'h5A; reg_write_en = 1'b1;
    tick();
    reg_wdata = 8'hFF;
    tick(3);
    reg_write_en = 1'b0;
    tick();
    rd("scratch_once", 8'h07, 8'h5A);

    wr(8'h01, 8'hFF);
    check("ctrl_outs", {5'b0, loopback, rx_en, tx_en}, 8'h07);
    rd("ctrl_rd", 8'h01, 8'h07);
    wr(8'h20, 8'h33);
    rd("unmapped_rd", 8'h20, 8'h00);
    rd("scratch_keep", 8'h07, 8'h5A);
    rd("ctrl_keep", 8'h01, 8'h07);

    wr(8'h02, 8'h3C);
    check("pll_before_apply", pll_cfg, 8'h14);
    rd("shadow_rd", 8'h02, 8'h3C);
    reg_addr = 8'h03; reg_wdata = 8'h01; reg_write_en = 1'b1;
    tick();
    check("pll_applied", pll_cfg, 8'h3C);
    reg_write_en = 1'b0;
    tick();
    rd("cmd_rd", 8'h03, 8'h00);

    wr(8'h06, 8'h07);
    rd("mask_rd", 8'h06, 8'h07);
    pll_lock_async = 1'b1; cdr_lock_async = 1'b1;
    tick(3);
    rd("status_locked", 8'h04, 8'h03);
    rd("stat_no_irq", 8'h05, 8'h00);
    pll_lock_async = 1'b0;
    tick(3);
    check("irq_latency", {7'b0, irq}, 8'h00);
    tick();
    check("stat_lock_lost", reg_rdata, 8'h01);
    check("irq_set", {7'b0, irq}, 8'h01);
    wr(8'h05, 8'h01);
    check("irq_clr", {7'b0, irq}, 8'h00);
    rd("stat_clr", 8'h05, 8'h00);

    reg_addr = 8'h05; reg_wdata = 8'h02; reg_write_en = 1'b1; fifo_ovf_pulse = 1'b1;
    tick();
    reg_write_en = 1'b0; fifo_ovf_pulse = 1'b0;
    tick();
    rd("ovf_beats_clr", 8'h05, 8'h02);
    check("irq_ovf", {7'b0, irq}, 8'h01);
    wr(8'h05, 8'h02);
    i2c_error = 1'b1;
    tick(2);
    rd("i2c_err_set", 8'h05, 8'h04);
    wr(8'h05, 8'h04);
    rd("i2c_level_no_reset", 8'h05, 8'h00);
    i2c_error = 1'b0;

    reg_addr = 8'h03; reg_wdata = 8'h02; reg_write_en = 1'b1;
    tick();
    check("srp_high", {7'b0, soft_reset_pulse}, 8'h01);
    reg_write_en = 1'b0;
    tick();
    check("srp_low", {7'b0, soft_reset_pulse}, 8'h00);
    check("ctrl_after_srp", {5'b0, loopback, rx_en, tx_en}, 8'h07);
    check("pll_after_srp", pll_cfg, 8'h3C);
    rd("scratch_after_srp", 8'h07, 8'h5A);

    reg_addr = 8'h07; reg_wdata = 8'h77; reg_write_en = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);
    check("rstrel_no_commit", reg_rdata, 8'h00);
    check("rstrel_ctrl", {5'b0, loopback, rx_en, tx_en}, 8'h00);
    check("rstrel_pll", pll_cfg, 8'h14);
    check("rstrel_srp_irq", {6'b0, soft_reset_pulse, irq}, 8'h00);
    reg_write_en = 1'b0;
    tick();
    wr(8'h07, 8'h77);
    rd("commit_after_rst", 8'h07, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
